// File: rtl/pipe_stage_chain_pkg.sv
// Shared helpers for parametrised flop/FIFO blocks.
// occ_width sizes a counter that must hold every value from 0 to depth inclusive.
package pipe_stage_chain_pkg;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_stage.sv
// One elastic register stage: a valid bit plus a payload word.
// Flush clears only the valid bit; the payload keeps its last value.
module pipe_stage #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Stage state: async reset, then flush, then load; otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VAL;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready pipeline of DEPTH stages with flush, bubble collapsing
// and occupancy reporting; out_valid/out_data come straight from the last stage.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               OCC_W     = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] w_stage_valid;
  logic [WIDTH-1:0] w_stage_data [DEPTH];
  logic [DEPTH-1:0] w_can_load;
  logic             w_hole_below;
  logic [OCC_W-1:0] w_occ;

  // Ready chain: a stage can load if it or any stage nearer the output has a hole, or out_ready.
  always_comb begin
    w_can_load   = '0;
    w_hole_below = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_hole_below  = w_hole_below | ~w_stage_valid[i];
      w_can_load[i] = w_hole_below;
    end
  end

  // Occupancy is the popcount of the stage valid flops.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(w_stage_valid[i]);
    end
  end

  assign in_ready = w_can_load[0] & ~flush;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             w_in_valid;
    logic [WIDTH-1:0] w_in_data;

    if (gi == 0) begin : g_head
      assign w_in_valid = in_valid & in_ready;
      assign w_in_data  = in_data;
    end else begin : g_body
      assign w_in_valid = w_stage_valid[gi-1];
      assign w_in_data  = w_stage_data[gi-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_flush (flush),
      .i_load  (w_can_load[gi]),
      .i_valid (w_in_valid),
      .i_data  (w_in_data),
      .o_valid (w_stage_valid[gi]),
      .o_data  (w_stage_data[gi])
    );
  end

  assign out_valid = w_stage_valid[DEPTH-1];
  assign out_data  = w_stage_data[DEPTH-1];
  assign occupancy = w_occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a DEPTH=3 instance driven from a vector
// table plus hand sequences, and a DEPTH=2 instance for full push/pop.
module tb_pipe_stage_chain;

  localparam logic [31:0] RV3 = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        f3, iv3, ir3, ov3, or3;
  logic [31:0] id3, od3;
  logic [1:0]  occ3;
  logic        f2, iv2, ir2, ov2, or2;
  logic [31:0] id2, od2;
  logic [1:0]  occ2;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(f3), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(occ3)
  );

  pipe_stage_chain #(.WIDTH(32), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .flush(f2), .in_valid(iv2), .in_ready(ir2),
    .in_data(id2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(occ2)
  );

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vecs [34];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: in_valid, in_data, out_ready, flush | in_ready, out_valid, out_data, occupancy
    vecs[0]  = '{1'b1, 32'h1,  1'b1, 1'b0, 1'b1, 1'b0, RV3,    2'd0};
    vecs[1]  = '{1'b1, 32'h2,  1'b1, 1'b0, 1'b1, 1'b0, RV3,    2'd1};
    vecs[2]  = '{1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 1'b0, RV3,    2'd2};
    vecs[3]  = '{1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1,  2'd3};
    vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h2,  2'd3};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h3,  2'd2};
    vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4,  2'd1};
    vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h4,  2'd0};
    // Backpressure fill: only three of A0..A4 get in.
    vecs[8]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4,  2'd0};
    vecs[9]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4,  2'd1};
    vecs[10] = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4,  2'd2};
    vecs[11] = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 2'd3};
    vecs[12] = '{1'b1, 32'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 2'd3};
    vecs[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 2'd3};
    vecs[14] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA1, 2'd2};
    vecs[15] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA2, 2'd1};
    vecs[16] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hA2, 2'd0};
    // Bubble collapse: 0x11, gap, 0x22 with out_ready low; 0x22 follows 0x11 back-to-back.
    vecs[17] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA2, 2'd0};
    vecs[18] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA2, 2'd1};
    vecs[19] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA2, 2'd1};
    vecs[20] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 2'd2};
    vecs[21] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 2'd2};
    vecs[22] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 2'd2};
    vecs[23] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 2'd1};
    vecs[24] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 2'd0};
    // Flush with 0x5,0x6 held and 0x7 offered; then 0x8 alone.
    vecs[25] = '{1'b1, 32'h5,  1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 2'd0};
    vecs[26] = '{1'b1, 32'h6,  1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 2'd1};
    vecs[27] = '{1'b1, 32'h7,  1'b0, 1'b1, 1'b0, 1'b0, 32'h22, 2'd2};
    vecs[28] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 2'd0};
    vecs[29] = '{1'b1, 32'h8,  1'b1, 1'b0, 1'b1, 1'b0, 32'h22, 2'd0};
    vecs[30] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h22, 2'd1};
    vecs[31] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h22, 2'd1};
    vecs[32] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h8,  2'd1};
    vecs[33] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h8,  2'd0};

    reset = 1'b1;
    {f3, iv3, or3} = 3'b000;
    {f2, iv2, or2} = 3'b000;
    id3 = 32'h0;
    id2 = 32'h0;
    #12;
    check("reset ov3",   32'(ov3),  32'h0);
    check("reset od3",   od3,       RV3);
    check("reset occ3",  32'(occ3), 32'h0);
    check("reset ir3",   32'(ir3),  32'h1);
    check("reset od2",   od2,       32'h0);
    check("reset occ2",  32'(occ2), 32'h0);
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 34; i++) begin
      iv3 = vecs[i].iv;
      id3 = vecs[i].id;
      or3 = vecs[i].ordy;
      f3  = vecs[i].fl;
      @(negedge clk);
      check($sformatf("row%0d in_ready", i),  32'(ir3),  32'(vecs[i].e_ir));
      check($sformatf("row%0d out_valid", i), 32'(ov3),  32'(vecs[i].e_ov));
      check($sformatf("row%0d out_data", i),  od3,       vecs[i].e_od);
      check($sformatf("row%0d occupancy", i), 32'(occ3), 32'(vecs[i].e_occ));
      next_cycle();
    end

    // Async reset between edges with two entries held.
    {iv3, or3, f3} = 3'b100;
    id3 = 32'hE1;
    next_cycle();
    id3 = 32'hE2;
    next_cycle();
    iv3 = 1'b0;
    check("pre-reset occ3", 32'(occ3), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("async ov3",  32'(ov3),  32'h0);
    check("async od3",  od3,       RV3);
    check("async occ3", 32'(occ3), 32'h0);
    #1;
    reset = 1'b0;
    next_cycle();
    iv3 = 1'b1;
    or3 = 1'b1;
    id3 = 32'hF1;
    @(negedge clk);
    check("post-reset ir3", 32'(ir3), 32'h1);
    next_cycle();
    iv3 = 1'b0;
    next_cycle();
    check("post-reset early ov3", 32'(ov3), 32'h0);
    next_cycle();
    check("post-reset ov3",  32'(ov3),  32'h1);
    check("post-reset od3",  od3,       32'hF1);
    check("post-reset occ3", 32'(occ3), 32'h1);

    // DEPTH=2: fill, then push and pop together for four cycles.
    iv2 = 1'b1;
    or2 = 1'b0;
    id2 = 32'h31;
    next_cycle();
    id2 = 32'h32;
    next_cycle();
    or2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      id2 = 32'h33 + 32'(k);
      @(negedge clk);
      check($sformatf("full%0d in_ready", k),  32'(ir2),  32'h1);
      check($sformatf("full%0d out_valid", k), 32'(ov2),  32'h1);
      check($sformatf("full%0d out_data", k),  od2,       32'h31 + 32'(k));
      check($sformatf("full%0d occupancy", k), 32'(occ2), 32'h2);
      next_cycle();
    end
    iv2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("drain%0d out_data", k),  od2,       32'h35 + 32'(k));
      check($sformatf("drain%0d occupancy", k), 32'(occ2), 32'(2 - k));
      next_cycle();
    end
    check("drained ov2", 32'(ov2), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised elastic pipeline register: a chain of DEPTH valid/ready stages with stall (backpressure), synchronous flush, bubble collapsing and occupancy reporting. It is the generalised successor to the plain resettable and enable flip-flops. The CPU pipeline and the memory/IO paths use it wherever a register stage must tolerate downstream stalls and branch/exception flushes without a hand-built enable/clear mux.

## Interface
- WIDTH, 32, payload bits per stage (≥1)
- DEPTH, 2, number of register stages (≥1)
- RESET_VAL, '0, payload value loaded into every stage on reset
- OCC_W, $clog2(DEPTH+1), occupancy width (derived, not overridden)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous: discard all held entries at the next edge
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  chain accepts in_data this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  last stage holds a valid entry
- out_ready  in  1  downstream consumes the last stage this cycle
- out_data  out  WIDTH  payload of last stage
- occupancy  out  OCC_W  number of valid stages

## Operation
- State per stage i (0 = input side, DEPTH-1 = output side): valid_i, data_i.
- Advance rule: stage DEPTH-1 can load when !valid_{DEPTH-1} or out_ready. Stage i<DEPTH-1 can load when !valid_i or stage i+1 can load. The ready chain is combinational, so bubbles collapse in one cycle.
- in_ready = (stage 0 can load) & !flush.
- Transfer into stage i when it can load. Stage 0 takes in_valid & in_ready. Stage i>0 takes valid_{i-1}. data_i loads only when the incoming valid is 1; otherwise data_i holds.
- Output handshake: an entry leaves when out_valid & out_ready. out_valid = valid_{DEPTH-1}, out_data = data_{DEPTH-1}, both driven straight from flops.
- Flush: at the next edge every valid_i is cleared and data_i holds. Any input offered in the flush cycle is dropped (in_ready=0). A downstream transfer in the flush cycle still counts as consumed; flush does not retract it.
- Order is strictly FIFO. There is no duplication and no loss except by flush.
- occupancy = popcount(valid_0..valid_{DEPTH-1}), combinational from flops.
- Reset: all valid_i=0, all data_i=RESET_VAL. Therefore out_valid=0, out_data=RESET_VAL, occupancy=0 and in_ready=1 while flush=0.

## Timing
- Latency: an entry accepted at edge k appears with out_valid=1 after edge k+DEPTH-1. That is DEPTH cycles from the in_valid&in_ready cycle to the first out_valid cycle, with no stalls.
- Throughput: 1 entry/cycle when out_ready is held at 1.
- Full chain with out_ready=0: in_ready=0 and every stage holds.
- Full chain with out_ready=1: in_ready=1, and a simultaneous push and pop keeps occupancy at DEPTH.
- Empty chain: out_valid=0 and out_ready is ignored.
- A bubble at stage j is filled by stage j-1 at the next edge even if out_ready=0.
- Reset asserted mid-transfer: all state clears asynchronously and the in-flight entry is lost. After deassertion the chain operates normally from the first edge.
- flush and reset together: reset dominates.

## Structure
- A shared package holds the occupancy-width helper (clog2 wrapper), reused by other parametrised flop/FIFO blocks.
- Natural sub-module: pipe_stage (one valid/data register with load/flush). The chain is instantiated with a generate loop, and the ready chain and popcount live in the top module.
- Internals must not use latches. The only asynchronous element is the reset.

## Test plan
- Reset then stream: WIDTH=32, DEPTH=3. Push 0x1,0x2,0x3,0x4 back-to-back with out_ready=1 → out_data 0x1..0x4 on consecutive cycles; the first out_valid comes 3 cycles after the first accept; occupancy peaks at 3.
- Backpressure fill: out_ready=0, push 5 entries (0xA0..0xA4) → exactly 3 accepted (in_ready falls after the 3rd), occupancy=3. Raise out_ready → 0xA0,0xA1,0xA2 in order, then the chain accepts again.
- Bubble collapse: DEPTH=3, push 0x11, idle 1 cycle, push 0x22, out_ready=0 → both entries end in adjacent output-side stages; occupancy=2; 0x11 exits first.
- Flush: chain holds 0x5,0x6 with in_valid=1 (0x7) and flush=1 for one cycle → next cycle out_valid=0, occupancy=0, 0x7 not accepted; the next push, 0x8, emerges alone after DEPTH cycles.
- Async reset mid-stream: assert reset between clock edges while occupancy=2 → out_valid=0, out_data=RESET_VAL and occupancy=0 immediately, without waiting for a clock edge; normal streaming resumes after release.
- Simultaneous push/pop at full: DEPTH=2 full, in_valid=1 and out_ready=1 held for 4 cycles → occupancy stays 2, one output per cycle, order preserved.
